seg7_mux_driver: RTL
====================

Name: seg7_mux_driver

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
- Generalises the fixed 4-digit board driver with:
  - configurable digit count and scan rate;
  - decimal points;
  - per-digit blank and blink;
  - 16-level PWM brightness;
  - tear-free frame-synchronous loading of display data.
- Sits between application logic (counters, FSMs) and the board's seg/dp/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 262144, clk cycles per digit slot; must be a multiple of 16
BLINK_FRAMES, 24, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset; asynchronous, active-high
value  in  4*NUM_DIGITS  hex digits; bits [3:0] = rightmost digit (index 0)
dp_en  in  NUM_DIGITS  decimal point on, per digit
blank  in  NUM_DIGITS  force digit dark, per digit
blink_en  in  NUM_DIGITS  digit blinks, per digit
bright  in  4  brightness 0 (1/16 duty) .. 15 (full duty)
load  in  1  one-cycle strobe; captures value/dp_en/blank/blink_en
busy  out  1  high while captured data is waiting for the frame boundary
frame_start  out  1  one-cycle pulse when the scan returns to digit 0
seg_L  out  7  segments g..a, active low
dp_L  out  1  decimal point, active low
anode_L  out  NUM_DIGITS  one-cold digit select, active low

Behaviour:
- Reset (async assert, sync release): all counters 0; active and pending data registers 0; blink_phase 0.
  - Outputs at reset: anode_L all 1, seg_L 7'h7F, dp_L 1, busy 0, frame_start 0.
- Sub-slot counter sub_cnt: counts 0..SCAN_DIV/16-1.
  - sub_tick is asserted when sub_cnt is at terminal count.
  - sub_idx (4 bits) increments on sub_tick.
  - slot_tick = sub_tick AND sub_idx==15.
- Digit index dig (clog2(NUM_DIGITS) bits): increments on slot_tick; wraps NUM_DIGITS-1 -> 0.
  - The wrap cycle is the frame boundary (fb).
  - frame_start is registered high for the single cycle after fb.
- Frame counter: counts frames 0..BLINK_FRAMES-1 on fb; toggles blink_phase at terminal count.
- Double buffering:
  - load captures all four inputs into pending and sets busy.
  - At fb with busy=1: pending -> active, busy cleared.
  - load while busy: pending overwritten (last wins); busy stays 1.
  - load in the same cycle as fb: input data goes straight into active and busy stays 0.
- Digit visibility: vis = active.blank[dig]==0 AND NOT (active.blink_en[dig] AND blink_phase).
  - The scanned anode bit is driven 0 only when vis AND sub_idx <= bright.
  - All other anode bits are 1.
- Decode (combinational from active data, then registered):
  - 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, A 08, b 03, C 46, d 21, E 06, F 0E (hex, seg_L).
  - When the digit is not lit: seg_L=7'h7F, dp_L=1.
  - Otherwise dp_L = ~active.dp_en[dig].
- Latency: seg_L, dp_L, anode_L are registered 1 cycle after the counters.
  - All three change in the same cycle, so there is no cross-digit ghosting.
- Bright changes take effect immediately: it is not buffered.
- Reset mid-frame: all outputs dark on the next evaluation; no partial load survives.
- With default SCAN_DIV and 4 digits: 2.62 ms per slot, 10.5 ms per frame, ~95 Hz refresh.

Decomposition:
- Package seg7_pkg holds:
  - the hex-to-segment constant table / function hex_to_seg(4b) -> 7b;
  - the blank pattern SEG_OFF = 7'h7F.
- One sub-module, seg7_scan_timer, generates sub_idx, dig, slot_tick, fb and blink_phase from clk/rst.
- The parent handles buffering, visibility and decode.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=32, BLINK_FRAMES=2. One frame = 128 cycles.
1. Reset, then load value=16'h12AF, bright=15, dp_en=0 → after the next fb:
   - anode_L cycles 1110, 1101, 1011, 0111, each for 32 cycles;
   - seg_L = 0E, 08, 24, 79 respectively; frame_start pulses every 128 cycles.
2. bright=3 → each anode bit low for 8 of 32 cycles (sub_idx 0..3), high for the rest; seg_L = 7F while dark.
3. load 16'h1111 mid-frame, then load 16'h2222 before fb:
   - busy=1 until fb; the current frame still shows the old value;
   - the next frame shows all "2" (24); busy returns to 0.
4. load asserted exactly in the fb cycle with 16'h8888 → busy stays 0; digit 0 shows 00 one cycle later.
5. blink_en=4'b0001, blank=4'b1000, dp_en=4'b0010:
   - digit 3 never lit;
   - digit 0 lit for 2 frames, dark for 2 frames;
   - dp_L=0 only in digit-1 slots.
6. Assert rst asynchronously mid-slot → anode_L=1111, seg_L=7F, busy=0 immediately, before any clk edge.
   - After release, scanning restarts at digit 0 showing value 0 (blank-free: 40).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment driver: hex glyph table and the dark pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segments g..a for a common-anode digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timebase: 16 PWM sub-slots per digit slot, digit index, frame boundary and blink phase.
module seg7_scan_timer #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned BLINK_FRAMES = 24,
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [3:0]       o_sub_idx,
  output logic [DIG_W-1:0] o_dig,
  output logic             o_fb,
  output logic             o_blink_phase
);

  localparam int unsigned SUB_DIV = SCAN_DIV / 16;
  localparam int unsigned SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SUB_W-1:0] r_sub_cnt;
  logic [3:0]       r_sub_idx;
  logic [DIG_W-1:0] r_dig;
  logic [FRM_W-1:0] r_frame;
  logic             r_blink_phase;

  logic w_sub_tick;
  logic w_slot_tick;
  logic w_dig_last;
  logic w_fb;
  logic w_frm_last;

  assign w_sub_tick  = (r_sub_cnt == SUB_W'(SUB_DIV - 1));
  assign w_slot_tick = w_sub_tick && (r_sub_idx == 4'hF);
  assign w_dig_last  = (r_dig == DIG_W'(NUM_DIGITS - 1));
  assign w_fb        = w_slot_tick && w_dig_last;
  assign w_frm_last  = (r_frame == FRM_W'(BLINK_FRAMES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sub_cnt     <= '0;
      r_sub_idx     <= '0;
      r_dig         <= '0;
      r_frame       <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_sub_cnt <= w_sub_tick ? '0 : r_sub_cnt + 1'b1;
      if (w_sub_tick)
        r_sub_idx <= r_sub_idx + 1'b1;
      if (w_slot_tick)
        r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
      if (w_fb) begin
        if (w_frm_last) begin
          r_frame       <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  assign o_sub_idx     = r_sub_idx;
  assign o_dig         = r_dig;
  assign o_fb          = w_fb;
  assign o_blink_phase = r_blink_phase;

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness, blink/blank
// and double-buffered display data swapped only at the frame boundary.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 262144,
  parameter int unsigned BLINK_FRAMES = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [3:0]              bright,
  input  logic                    load,
  output logic                    busy,
  output logic                    frame_start,
  output logic [6:0]              seg_L,
  output logic                    dp_L,
  output logic [NUM_DIGITS-1:0]   anode_L
);

  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [3:0]       w_sub_idx;
  logic [DIG_W-1:0] w_dig;
  logic             w_fb;
  logic             w_blink_phase;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_sub_idx    (w_sub_idx),
    .o_dig        (w_dig),
    .o_fb         (w_fb),
    .o_blink_phase(w_blink_phase)
  );

  logic [4*NUM_DIGITS-1:0] r_act_value, r_pend_value;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
  logic [NUM_DIGITS-1:0]   r_act_blink, r_pend_blink;
  logic                    r_busy;

  // A load coinciding with the boundary bypasses pending so it is never lost or delayed a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_act_blink  <= '0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_blink <= '0;
      r_busy       <= 1'b0;
    end else if (w_fb) begin
      r_busy <= 1'b0;
      if (load) begin
        r_act_value <= value;
        r_act_dp    <= dp_en;
        r_act_blank <= blank;
        r_act_blink <= blink_en;
      end else if (r_busy) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_blank <= r_pend_blank;
        r_act_blink <= r_pend_blink;
      end
    end else if (load) begin
      r_pend_value <= value;
      r_pend_dp    <= dp_en;
      r_pend_blank <= blank;
      r_pend_blink <= blink_en;
      r_busy       <= 1'b1;
    end
  end

  logic [3:0]            w_nib;
  logic                  w_vis;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_anode;

  assign w_nib = r_act_value[4*w_dig +: 4];
  assign w_vis = ~r_act_blank[w_dig] & ~(r_act_blink[w_dig] & w_blink_phase);
  assign w_lit = w_vis && (w_sub_idx <= bright);

  always_comb begin
    w_anode = '1;
    if (w_lit)
      w_anode[w_dig] = 1'b0;
  end

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_anode;
  logic                  r_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_anode       <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= w_lit ? hex_to_seg(w_nib) : SEG_OFF;
      r_dp          <= w_lit ? ~r_act_dp[w_dig] : 1'b1;
      r_anode       <= w_anode;
      r_frame_start <= w_fb;
    end
  end

  assign busy        = r_busy;
  assign frame_start = r_frame_start;
  assign seg_L       = r_seg;
  assign dp_L        = r_dp;
  assign anode_L     = r_anode;

endmodule
